// File: rtl/dbus_rsp_model.sv
// In-order dBus response model with a byte-accurate shadow of one tracked word.
// Loads respond no earlier than the cycle after acceptance; stall via rand_cmd_ready or a full queue.
module dbus_rsp_model #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      track_addr,
    input  logic [31:0]      init_data,
    input  logic             cmd_valid,
    input  logic             cmd_wr,
    input  logic [31:0]      cmd_address,
    input  logic [31:0]      cmd_data,
    input  logic [1:0]       cmd_size,
    output logic             cmd_ready,
    input  logic             rand_cmd_ready,
    input  logic             rand_rsp_en,
    input  logic [31:0]      rand_rsp_data,
    output logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_error,
    output logic [CNT_W-1:0] pending,
    output logic [31:0]      shadow_data
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic        hit;
        logic [31:0] snap;
    } entry_t;

    entry_t            fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  pending_q, pending_d;
    logic [31:0]       shadow_q, shadow_d;

    logic       hit;
    logic [1:0] size_eff;
    logic [3:0] base_mask;
    logic [3:0] mask;
    logic       push;
    logic       pop;
    logic       store_acc;
    logic       unused_track_lsb;

    assign unused_track_lsb = ^track_addr[1:0];

    assign hit       = (cmd_address[31:2] == track_addr[31:2]);
    assign size_eff  = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
    assign base_mask = (size_eff == 2'd0) ? 4'b0001 :
                       (size_eff == 2'd1) ? 4'b0011 : 4'b1111;
    // Lanes shifted past byte 3 are dropped, matching a 4-bit truncation.
    assign mask      = base_mask << cmd_address[1:0];

    assign cmd_ready = !reset && rand_cmd_ready && (pending_q != CNT_W'(DEPTH));
    assign rsp_ready = !reset && rand_rsp_en && (pending_q != '0);
    assign push      = cmd_valid && cmd_ready && !cmd_wr;
    assign store_acc = cmd_valid && cmd_ready && cmd_wr;
    assign pop       = rsp_ready;

    assign rsp_data    = (rsp_ready && fifo_q[rd_ptr_q].hit) ? fifo_q[rd_ptr_q].snap : rand_rsp_data;
    assign rsp_error   = 1'b0;
    assign pending     = pending_q;
    assign shadow_data = shadow_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   pending_d = pending_q + CNT_W'(1);
            2'b01:   pending_d = pending_q - CNT_W'(1);
            default: pending_d = pending_q;
        endcase
        if (store_acc && hit) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) shadow_d[8*i +: 8] = cmd_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pending_q <= '0;
            shadow_q  <= init_data;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
        end
    end

    // Snapshot is the pre-update shadow; a load and a store never share a cycle.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= '{hit: hit, snap: shadow_q};
    end

`ifdef FORMAL
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (pending_q <= CNT_W'(DEPTH));
            assert (!(rsp_ready && pending_q == '0));
        end
    end
`endif

endmodule

// File: tb/tb_dbus_rsp_model.sv
// Scenario bench for dbus_rsp_model with a reference-model scoreboard of queued loads.
module tb_dbus_rsp_model;
    logic        clk;
    logic        reset;
    logic [31:0] track_addr;
    logic [31:0] init_data;
    logic        cmd_valid;
    logic        cmd_wr;
    logic [31:0] cmd_address;
    logic [31:0] cmd_data;
    logic [1:0]  cmd_size;
    logic        cmd_ready;
    logic        rand_cmd_ready;
    logic        rand_rsp_en;
    logic [31:0] rand_rsp_data;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic [2:0]  pending;
    logic [31:0] shadow_data;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        hit;
        logic [31:0] snap;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] m_shadow;

    dbus_rsp_model #(.DEPTH(4), .CNT_W(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .track_addr    (track_addr),
        .init_data     (init_data),
        .cmd_valid     (cmd_valid),
        .cmd_wr        (cmd_wr),
        .cmd_address   (cmd_address),
        .cmd_data      (cmd_data),
        .cmd_size      (cmd_size),
        .cmd_ready     (cmd_ready),
        .rand_cmd_ready(rand_cmd_ready),
        .rand_rsp_en   (rand_rsp_en),
        .rand_rsp_data (rand_rsp_data),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_error     (rsp_error),
        .pending       (pending),
        .shadow_data   (shadow_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: evaluated mid-cycle, when inputs for the next edge are stable.
    always @(negedge clk) begin
        logic        exp_cr;
        logic        exp_rr;
        logic [31:0] exp_d;
        ent_t        e;
        int          off;
        int          nbytes;
        exp_cr = !reset && rand_cmd_ready && (exp_q.size() != 4);
        exp_rr = !reset && rand_rsp_en && (exp_q.size() != 0);
        n_tests++;
        if (cmd_ready !== exp_cr) begin
            n_fail++;
            $display("FAIL sb_cmd_ready: got %b expected %b at %0t", cmd_ready, exp_cr, $time);
        end
        n_tests++;
        if (rsp_ready !== exp_rr) begin
            n_fail++;
            $display("FAIL sb_rsp_ready: got %b expected %b at %0t", rsp_ready, exp_rr, $time);
        end
        n_tests++;
        if (pending !== 3'(exp_q.size())) begin
            n_fail++;
            $display("FAIL sb_pending: got %0d expected %0d at %0t", pending, exp_q.size(), $time);
        end
        n_tests++;
        if (shadow_data !== m_shadow) begin
            n_fail++;
            $display("FAIL sb_shadow: got %h expected %h at %0t", shadow_data, m_shadow, $time);
        end
        n_tests++;
        if (rsp_error !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_rsp_error: got %b expected 0 at %0t", rsp_error, $time);
        end
        if (reset) begin
            exp_q.delete();
            m_shadow = init_data;
        end else begin
            if (exp_rr) begin
                e = exp_q.pop_front();
                exp_d = e.hit ? e.snap : rand_rsp_data;
                n_tests++;
                if (rsp_data !== exp_d) begin
                    n_fail++;
                    $display("FAIL sb_rsp_data: got %h expected %h at %0t", rsp_data, exp_d, $time);
                end
            end
            if (cmd_valid && exp_cr) begin
                if (!cmd_wr) begin
                    exp_q.push_back('{hit: (cmd_address[31:2] == track_addr[31:2]), snap: m_shadow});
                end else if (cmd_address[31:2] == track_addr[31:2]) begin
                    off    = int'(cmd_address[1:0]);
                    nbytes = (cmd_size == 2'd0) ? 1 : (cmd_size == 2'd1) ? 2 : 4;
                    for (int i = 0; i < 4; i++) begin
                        if (i >= off && (i - off) < nbytes) m_shadow[8*i +: 8] = cmd_data[8*i +: 8];
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] sz);
        cmd_valid   = v;
        cmd_wr      = wr;
        cmd_address = a;
        cmd_data    = d;
        cmd_size    = sz;
    endtask

    task automatic drain();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
        rand_rsp_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_rsp_data = $urandom;
            step();
        end
        rand_rsp_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        @(negedge clk);
        n_tests++;
        if (pending !== 3'd0 || rsp_ready !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pending=%0d rsp_ready=%b cmd_ready=%b expected 0/0/0",
                     pending, rsp_ready, cmd_ready);
        end
        n_tests++;
        if (shadow_data !== 32'hAABBCCDD) begin
            n_fail++;
            $display("FAIL reset_shadow: got %h expected aabbccdd", shadow_data);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_load();
        set_cmd(1'b1, 1'b0, 32'h100, 32'h0, 2'd2);
        rand_rsp_en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rsp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_same_cycle: rsp_ready=%b expected 0", rsp_ready);
        end
        step();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
        @(negedge clk);
        n_tests++;
        if (rsp_ready !== 1'b1 || rsp_data !== 32'hAABBCCDD) begin
            n_fail++;
            $display("FAIL basic_load: rsp_ready=%b data=%h expected 1/aabbccdd", rsp_ready, rsp_data);
        end
        step();
        rand_rsp_en = 1'b0;
        step();
    endtask

    task automatic test_store_byte();
        set_cmd(1'b1, 1'b1, 32'h102, 32'h0011_0000, 2'd0);
        step();
        set_cmd(1'b1, 1'b0, 32'h100, 32'h0, 2'd2);
        @(negedge clk);
        n_tests++;
        if (shadow_data !== 32'hAA11CCDD) begin
            n_fail++;
            $display("FAIL store_byte_shadow: got %h expected aa11ccdd", shadow_data);
        end
        step();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
        rand_rsp_en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rsp_ready !== 1'b1 || rsp_data !== 32'hAA11CCDD) begin
            n_fail++;
            $display("FAIL store_byte_load: rsp_ready=%b data=%h expected 1/aa11ccdd", rsp_ready, rsp_data);
        end
        step();
        rand_rsp_en = 1'b0;
    endtask

    task automatic test_snap_old();
        set_cmd(1'b1, 1'b0, 32'h100, 32'h0, 2'd2);
        step();
        set_cmd(1'b1, 1'b1, 32'h100, 32'h1234_5678, 2'd2);
        step();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
        rand_rsp_en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (shadow_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL snap_shadow: got %h expected 12345678", shadow_data);
        end
        n_tests++;
        if (rsp_ready !== 1'b1 || rsp_data !== 32'hAA11CCDD) begin
            n_fail++;
            $display("FAIL snap_old: rsp_ready=%b data=%h expected 1/aa11ccdd", rsp_ready, rsp_data);
        end
        step();
        rand_rsp_en = 1'b0;
    endtask

    task automatic test_full();
        logic [31:0] addrs [4];
        addrs[0] = 32'h100; addrs[1] = 32'h200; addrs[2] = 32'h103; addrs[3] = 32'h300;
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b1, 1'b0, addrs[i], 32'h0, 2'd2);
            step();
        end
        set_cmd(1'b1, 1'b0, 32'h100, 32'h0, 2'd2);
        @(negedge clk);
        n_tests++;
        if (pending !== 3'd4 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: pending=%0d cmd_ready=%b expected 4/0", pending, cmd_ready);
        end
        step();
        rand_rsp_en   = 1'b1;
        rand_rsp_data = 32'hCAFE_0001;
        @(negedge clk);
        n_tests++;
        if (cmd_ready !== 1'b0 || rsp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop: cmd_ready=%b rsp_ready=%b expected 0/1", cmd_ready, rsp_ready);
        end
        step();
        rand_rsp_data = 32'hCAFE_0002;
        @(negedge clk);
        n_tests++;
        if (pending !== 3'd3 || cmd_ready !== 1'b1 || rsp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pushpop: pending=%0d cmd_ready=%b rsp_ready=%b expected 3/1/1",
                     pending, cmd_ready, rsp_ready);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (pending !== 3'd3) begin
            n_fail++;
            $display("FAIL full_hold: pending=%0d expected 3", pending);
        end
        drain();
    endtask

    task automatic test_miss_order();
        set_cmd(1'b1, 1'b0, 32'h200, 32'h0, 2'd2);
        step();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
        rand_rsp_en   = 1'b1;
        rand_rsp_data = 32'hDEADBEEF;
        @(negedge clk);
        n_tests++;
        if (rsp_ready !== 1'b1 || rsp_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL miss_data: rsp_ready=%b data=%h expected 1/deadbeef", rsp_ready, rsp_data);
        end
        step();
        rand_rsp_en = 1'b0;
        set_cmd(1'b1, 1'b0, 32'h100, 32'h0, 2'd2);
        step();
        set_cmd(1'b1, 1'b0, 32'h204, 32'h0, 2'd2);
        step();
        set_cmd(1'b1, 1'b1, 32'h101, 32'h0000_9900, 2'd0);
        step();
        set_cmd(1'b1, 1'b0, 32'h100, 32'h0, 2'd2);
        step();
        drain();
    endtask

    task automatic test_random();
        logic [31:0] addr_tbl [6];
        addr_tbl[0] = 32'h100; addr_tbl[1] = 32'h101; addr_tbl[2] = 32'h102;
        addr_tbl[3] = 32'h103; addr_tbl[4] = 32'h200; addr_tbl[5] = 32'h104;
        for (int i = 0; i < 300; i++) begin
            set_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    addr_tbl[$urandom_range(0, 5)], $urandom, 2'($urandom_range(0, 3)));
            rand_cmd_ready = ($urandom_range(0, 3) != 0);
            rand_rsp_en    = 1'($urandom_range(0, 1));
            rand_rsp_data  = $urandom;
            step();
        end
        rand_cmd_ready = 1'b1;
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_cmd(1'b1, 1'b0, (i == 1) ? 32'h200 : 32'h100, 32'h0, 2'd2);
            step();
        end
        set_cmd(1'b1, 1'b1, 32'h100, 32'h5555_5555, 2'd2);
        step();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
        reset       = 1'b1;
        rand_rsp_en = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (pending !== 3'd0 || rsp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: pending=%0d rsp_ready=%b expected 0/0", pending, rsp_ready);
        end
        n_tests++;
        if (shadow_data !== 32'hAABBCCDD) begin
            n_fail++;
            $display("FAIL reset_mid_shadow: got %h expected aabbccdd", shadow_data);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (rsp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: rsp_ready=%b expected 0", rsp_ready);
        end
        step();
        rand_rsp_en = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        track_addr     = 32'h100;
        init_data      = 32'hAABBCCDD;
        m_shadow       = 32'hAABBCCDD;
        rand_cmd_ready = 1'b1;
        rand_rsp_en    = 1'b0;
        rand_rsp_data  = 32'h0;
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
        test_reset();
        test_basic_load();
        test_store_byte();
        test_snap_old();
        test_full();
        test_miss_order();
        test_random();
        test_reset_mid();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
